// File: rtl/pfrv_trap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pfrv_trap_pkg
// Description : Shared constants, state encoding and helpers for the
//               machine-mode trap sequencer.
// Revision    : 1.0
// ============================================================================
package pfrv_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MIE    = 3;
  localparam int MPIE   = 7;
  localparam int MPP_LO = 11;
  localparam int MPP_HI = 12;

  localparam logic [5:0] NO_EXC = 6'h1F;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    W_EPC      = 3'd1,
    W_CAUSE    = 3'd2,
    W_TVAL     = 3'd3,
    W_STATUS   = 3'd4,
    REDIRECT   = 3'd5,
    R_STATUS   = 3'd6,
    R_REDIRECT = 3'd7
  } trap_state_t;

  // Environment calls from U, S and M mode carry no faulting value.
  function automatic logic is_ecall(input logic [5:0] code);
    return (code == 6'd8) || (code == 6'd9) || (code == 6'd11);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mstatus_update.sv
`default_nettype none
// ============================================================================
// Module      : mstatus_update
// Description : Pure combinational mstatus rewrite for trap entry and mret.
// Revision    : 1.0
// ============================================================================
module mstatus_update #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_mstatus,
  input  logic [1:0]      i_trap_priv,
  output logic [XLEN-1:0] o_trap_mstatus,
  output logic [XLEN-1:0] o_mret_mstatus,
  output logic [1:0]      o_mret_priv
);
  import pfrv_trap_pkg::*;

  always_comb begin
    o_trap_mstatus               = i_mstatus;
    o_trap_mstatus[MPIE]         = i_mstatus[MIE];
    o_trap_mstatus[MIE]          = 1'b0;
    o_trap_mstatus[MPP_HI:MPP_LO] = i_trap_priv;

    o_mret_mstatus               = i_mstatus;
    o_mret_mstatus[MIE]          = i_mstatus[MPIE];
    o_mret_mstatus[MPIE]         = 1'b1;
    o_mret_mstatus[MPP_HI:MPP_LO] = PRIV_U;

    o_mret_priv                  = i_mstatus[MPP_HI:MPP_LO];
  end

endmodule
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer
// Description : Machine-mode trap entry / mret sequencer driving a single
//               shared CSR write port, pipeline stall/flush and fetch redirect.
// Revision    : 1.0
// ============================================================================
module trap_sequencer #(
  parameter int         XLEN   = 64,
  parameter logic [5:0] NO_EXC = pfrv_trap_pkg::NO_EXC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_req,
  input  logic [1:0]      cur_priv,
  input  logic [XLEN-1:0] mtvec_q,
  input  logic [XLEN-1:0] mepc_q,
  input  logic [XLEN-1:0] mstatus_q,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            priv_we,
  output logic [1:0]      priv_next
);
  import pfrv_trap_pkg::*;

  trap_state_t     r_state;
  logic [5:0]      r_code;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tval;
  logic [1:0]      r_priv;

  logic [XLEN-1:0] w_trap_mstatus;
  logic [XLEN-1:0] w_mret_mstatus;
  logic [1:0]      w_mret_priv;
  logic            w_unused_bits;

  assign w_unused_bits = ^{mtvec_q[1:0], exc_pc[0]};

  mstatus_update #(
    .XLEN (XLEN)
  ) u_mstatus_update (
    .i_mstatus      (mstatus_q),
    .i_trap_priv    (r_priv),
    .o_trap_mstatus (w_trap_mstatus),
    .o_mret_mstatus (w_mret_mstatus),
    .o_mret_priv    (w_mret_priv)
  );

  // Outputs are registered: each branch computes what the *next* state drives,
  // so mstatus_q/mtvec_q/mepc_q are sampled one cycle before they appear.
  // The pipeline is stalled throughout, so those CSRs are stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_code         <= '0;
      r_pc           <= '0;
      r_tval         <= '0;
      r_priv         <= '0;
      csr_we         <= 1'b0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      stall          <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      priv_we        <= 1'b0;
      priv_next      <= '0;
    end else begin
      csr_we         <= 1'b0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      priv_we        <= 1'b0;
      priv_next      <= '0;

      case (r_state)
        IDLE: begin
          if (exc_code != NO_EXC) begin
            r_code    <= exc_code;
            r_pc      <= exc_pc;
            r_tval    <= exc_tval;
            r_priv    <= cur_priv;
            r_state   <= W_EPC;
            stall     <= 1'b1;
            csr_we    <= 1'b1;
            csr_addr  <= CSR_MEPC;
            csr_wdata <= {exc_pc[XLEN-1:1], 1'b0};
          end else if (mret_req) begin
            r_priv    <= cur_priv;
            r_state   <= R_STATUS;
            stall     <= 1'b1;
            csr_we    <= 1'b1;
            csr_addr  <= CSR_MSTATUS;
            csr_wdata <= w_mret_mstatus;
            priv_we   <= 1'b1;
            priv_next <= w_mret_priv;
          end else begin
            stall     <= 1'b0;
          end
        end
        W_EPC: begin
          r_state   <= W_CAUSE;
          stall     <= 1'b1;
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MCAUSE;
          csr_wdata <= {{(XLEN-6){1'b0}}, r_code};
        end
        W_CAUSE: begin
          r_state   <= W_TVAL;
          stall     <= 1'b1;
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MTVAL;
          csr_wdata <= is_ecall(r_code) ? '0 : r_tval;
        end
        W_TVAL: begin
          r_state   <= W_STATUS;
          stall     <= 1'b1;
          csr_we    <= 1'b1;
          csr_addr  <= CSR_MSTATUS;
          csr_wdata <= w_trap_mstatus;
          priv_we   <= 1'b1;
          priv_next <= PRIV_M;
        end
        W_STATUS: begin
          // Direct mode only: no interrupts, so the vectored bits are dropped.
          r_state        <= REDIRECT;
          stall          <= 1'b1;
          flush          <= 1'b1;
          redirect_valid <= 1'b1;
          redirect_pc    <= {mtvec_q[XLEN-1:2], 2'b00};
        end
        R_STATUS: begin
          r_state        <= R_REDIRECT;
          stall          <= 1'b1;
          flush          <= 1'b1;
          redirect_valid <= 1'b1;
          redirect_pc    <= mepc_q;
        end
        REDIRECT, R_REDIRECT: begin
          r_state <= IDLE;
          stall   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          stall   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_sequencer
// Description : Self-checking bench for trap_sequencer against a per-cycle
//               behavioural model of trap entry and mret.
// Revision    : 1.0
// ============================================================================
module tb_trap_sequencer;

  localparam int         XLEN   = 64;
  localparam logic [5:0] NO_EXC = 6'h1F;

  logic            clk = 1'b0;
  logic            reset;
  logic [5:0]      exc_code;
  logic [XLEN-1:0] exc_pc, exc_tval;
  logic            mret_req;
  logic [1:0]      cur_priv;
  logic [XLEN-1:0] mtvec_q, mepc_q, mstatus_q;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            stall, flush, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            priv_we;
  logic [1:0]      priv_next;

  typedef struct packed {
    logic            we;
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
    logic            stall;
    logic            flush;
    logic            rv;
    logic [XLEN-1:0] rpc;
    logic            pwe;
    logic [1:0]      pnext;
  } obs_t;

  obs_t exp_q[$];
  obs_t got;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  trap_sequencer #(.XLEN(XLEN), .NO_EXC(NO_EXC)) dut (
    .clk            (clk),
    .reset          (reset),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .mret_req       (mret_req),
    .cur_priv       (cur_priv),
    .mtvec_q        (mtvec_q),
    .mepc_q         (mepc_q),
    .mstatus_q      (mstatus_q),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .priv_we        (priv_we),
    .priv_next      (priv_next)
  );

  function automatic obs_t sample_obs();
    return '{csr_we, csr_addr, csr_wdata, stall, flush, redirect_valid,
             redirect_pc, priv_we, priv_next};
  endfunction

  // Address/data, target and privilege are only meaningful with their strobe.
  function automatic obs_t mask_obs(obs_t g, obs_t e);
    if (!e.we) begin
      g.addr  = '0;
      g.wdata = '0;
    end
    if (!e.rv)  g.rpc   = '0;
    if (!e.pwe) g.pnext = '0;
    return g;
  endfunction

  function automatic obs_t mk(logic we, logic [11:0] a, logic [XLEN-1:0] d,
                              logic st, logic rv, logic [XLEN-1:0] pc,
                              logic pwe, logic [1:0] pn);
    return '{we, a, d, st, rv, rv, pc, pwe, pn};
  endfunction

  task automatic model_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic model_trap(input logic [5:0] code, input logic [XLEN-1:0] pc,
                            input logic [XLEN-1:0] tval, input logic [1:0] priv,
                            input logic [XLEN-1:0] mtvec, input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] mtval_v, st;
    mtval_v = (code == 8 || code == 9 || code == 11) ? '0 : tval;
    st = (ms & ~64'h1888) | (((ms >> 3) & 64'h1) << 7) | (64'(priv) << 11);
    exp_q.push_back(mk(1, 12'h341, pc & ~64'h1, 1, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 12'h342, 64'(code), 1, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 12'h343, mtval_v, 1, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 12'h300, st, 1, 0, 0, 1, 2'b11));
    exp_q.push_back(mk(0, 0, 0, 1, 1, mtvec & ~64'h3, 0, 0));
    model_idle(1);
  endtask

  task automatic model_mret(input logic [XLEN-1:0] ms, input logic [XLEN-1:0] mepc);
    logic [XLEN-1:0] st;
    st = (ms & ~64'h1888) | (((ms >> 7) & 64'h1) << 3) | (64'h1 << 7);
    exp_q.push_back(mk(1, 12'h300, st, 1, 0, 0, 1, 2'((ms >> 11) & 64'h3)));
    exp_q.push_back(mk(0, 0, 0, 1, 1, mepc, 0, 0));
    model_idle(1);
  endtask

  task automatic idle_inputs();
    exc_code = NO_EXC;
    mret_req = 1'b0;
  endtask

  task automatic drive_trap(input logic [5:0] code, input logic [XLEN-1:0] pc,
                            input logic [XLEN-1:0] tval, input logic [1:0] priv);
    exc_code = code; exc_pc = pc; exc_tval = tval; cur_priv = priv;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_trap(6'd4, 64'h1234, 64'h5678, 2'd0);
    mret_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (sample_obs() !== '0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %h want 0", i, sample_obs());
      end
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_load_misalign();
    int stall_cycles = 0;
    exp_q.delete();
    mtvec_q = 64'h8000_0101; mstatus_q = 64'h8;
    model_trap(6'd4, 64'h8000_0010, 64'h1003, 2'd0, mtvec_q, mstatus_q);
    @(negedge clk);
    drive_trap(6'd4, 64'h8000_0010, 64'h1003, 2'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) idle_inputs();
      if (stall) stall_cycles++;
      got = mask_obs(sample_obs(), exp_q[i]);
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL misalign cycle T+%0d: got %h want %h", i + 1, got, exp_q[i]);
      end
    end
    n_checks++;
    if (stall_cycles != 5) begin
      n_fail++;
      $display("FAIL misalign stall length: got %0d want 5", stall_cycles);
    end
  endtask

  task automatic test_ecall();
    exp_q.delete();
    mtvec_q = 64'h0000_0000_0000_4000; mstatus_q = 64'h0;
    model_trap(6'd8, 64'h2000_0044, 64'hDEAD, 2'd0, mtvec_q, mstatus_q);
    @(negedge clk);
    drive_trap(6'd8, 64'h2000_0044, 64'hDEAD, 2'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) idle_inputs();
      got = mask_obs(sample_obs(), exp_q[i]);
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ecall cycle T+%0d: got %h want %h", i + 1, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_mret();
    exp_q.delete();
    mstatus_q = 64'h80; mepc_q = 64'h8000_0200;
    model_mret(mstatus_q, mepc_q);
    @(negedge clk);
    exc_code = NO_EXC; mret_req = 1'b1; cur_priv = 2'b11;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) idle_inputs();
      got = mask_obs(sample_obs(), exp_q[i]);
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mret cycle T+%0d: got %h want %h", i + 1, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_exc_and_mret();
    exp_q.delete();
    mtvec_q = 64'h8000_0000; mstatus_q = 64'h1888; mepc_q = 64'h7777_0000;
    model_trap(6'd2, 64'h8000_0301, 64'h0BAD, 2'd3, mtvec_q, mstatus_q);
    @(negedge clk);
    drive_trap(6'd2, 64'h8000_0301, 64'h0BAD, 2'd3);
    mret_req = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) idle_inputs();
      got = mask_obs(sample_obs(), exp_q[i]);
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL exc_vs_mret cycle T+%0d: got %h want %h", i + 1, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_ignore_midsequence();
    int writes = 0;
    exp_q.delete();
    mtvec_q = 64'h9000_0004; mstatus_q = 64'h0;
    model_trap(6'd2, 64'h8000_0400, 64'h1111, 2'd1, mtvec_q, mstatus_q);
    model_idle(2);
    @(negedge clk);
    drive_trap(6'd2, 64'h8000_0400, 64'h1111, 2'd1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) idle_inputs();
      if (i == 1) begin exc_code = 6'd5; mret_req = 1'b1; end
      if (i == 2) idle_inputs();
      if (csr_we) writes++;
      got = mask_obs(sample_obs(), exp_q[i]);
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ignore cycle T+%0d: got %h want %h", i + 1, got, exp_q[i]);
      end
    end
    n_checks++;
    if (writes != 4) begin
      n_fail++;
      $display("FAIL ignore write count: got %0d want 4", writes);
    end
  endtask

  task automatic test_reset_midsequence();
    exp_q.delete();
    mtvec_q = 64'hA000_0000; mstatus_q = 64'h8;
    model_trap(6'd6, 64'h8000_0500, 64'h2222, 2'd0, mtvec_q, mstatus_q);
    @(negedge clk);
    drive_trap(6'd6, 64'h8000_0500, 64'h2222, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) idle_inputs();
      got = mask_obs(sample_obs(), exp_q[i]);
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rst_mid cycle T+%0d: got %h want %h", i + 1, got, exp_q[i]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (sample_obs() !== '0) begin
      n_fail++;
      $display("FAIL rst_mid abort: got %h want 0", sample_obs());
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (csr_we || redirect_valid || flush || stall) begin
        n_fail++;
        $display("FAIL rst_mid after abort cycle %0d: got %h want idle", i, sample_obs());
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]      code;
    logic [XLEN-1:0] pc, tval;
    logic [1:0]      priv;
    for (int n = 0; n < 24; n++) begin
      exp_q.delete();
      code = 6'($urandom_range(0, 63));
      pc = {$urandom, $urandom}; tval = {$urandom, $urandom};
      priv = 2'($urandom_range(0, 3));
      mtvec_q = {$urandom, $urandom}; mstatus_q = {$urandom, $urandom};
      mepc_q = {$urandom, $urandom};
      if (code == NO_EXC) model_mret(mstatus_q, mepc_q);
      else model_trap(code, pc, tval, priv, mtvec_q, mstatus_q);
      // Back-to-back: the new request lands in the IDLE cycle just sampled.
      drive_trap(code, pc, tval, priv);
      mret_req = 1'($urandom_range(0, 1)) | (code == NO_EXC);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        if (i == 0) idle_inputs();
        got = mask_obs(sample_obs(), exp_q[i]);
        n_checks++;
        if (got !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random #%0d code %0d cycle T+%0d: got %h want %h",
                   n, code, i + 1, got, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    exc_pc = '0; exc_tval = '0; cur_priv = '0;
    mtvec_q = '0; mepc_q = '0; mstatus_q = '0;
    test_reset();
    test_load_misalign();
    test_ecall();
    test_mret();
    test_exc_and_mret();
    test_ignore_midsequence();
    test_reset_midsequence();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap controller that sits between the exception-code decoder and the CSR file / fetch unit.
- On a decoded exception it stalls the pipeline and sequences the architectural trap-entry writes (mepc, mcause, mtval, mstatus) over one shared CSR write port.
- It then flushes the pipeline and redirects fetch to mtvec.
- It also sequences mret: it restores mstatus and the privilege level, then redirects to mepc.

Parameters:
- XLEN, 64, datapath / CSR width.
- NO_EXC, 6'h1F, decoder code meaning "no exception".

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- exc_code  in  6  cause code from the exception decoder; NO_EXC when idle
- exc_pc  in  XLEN  PC of the faulting instruction
- exc_tval  in  XLEN  faulting address or instruction bits
- mret_req  in  1  mret retiring this cycle
- cur_priv  in  2  current privilege level
- mtvec_q  in  XLEN  current mtvec
- mepc_q  in  XLEN  current mepc
- mstatus_q  in  XLEN  current mstatus
- csr_we  out  1  CSR write strobe
- csr_addr  out  12  CSR write address
- csr_wdata  out  XLEN  CSR write data
- stall  out  1  freezes pipeline
- flush  out  1  one-cycle squash of all in-flight instructions
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  XLEN  redirect target
- priv_we  out  1  privilege update strobe
- priv_next  out  2  new privilege level

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: all outputs 0; state IDLE; capture registers 0. A reset asserted mid-sequence aborts it the same edge, with no further CSR write and no redirect.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIRECT, R_STATUS, R_REDIRECT.
- IDLE, exc_code != NO_EXC:
  - Latch code, exc_pc, exc_tval, cur_priv.
  - Go to W_EPC.
  - Assert stall from the next cycle.
- IDLE, exc_code == NO_EXC and mret_req: latch cur_priv; go to R_STATUS.
- Exception and mret_req in the same IDLE cycle: the exception wins and mret_req is dropped.
- W_EPC: csr_we=1, addr 12'h341, wdata = {latched pc[XLEN-1:1],1'b0}.
- W_CAUSE: addr 12'h342, wdata = zero-extended 6-bit code. The interrupt bit is always 0.
- W_TVAL: addr 12'h343, wdata = latched tval. Write 0 when the code is 8, 9 or 11 (ecall).
- W_STATUS: addr 12'h300, wdata = mstatus_q with:
  - MPIE[7] <= MIE[3]
  - MIE[3] <= 0
  - MPP[12:11] <= latched priv
  - priv_we=1, priv_next=2'b11.
- REDIRECT:
  - flush=1, redirect_valid=1, redirect_pc = {mtvec_q[XLEN-1:2],2'b00}. Vectored mode is ignored because there are no interrupts.
  - stall deasserts the following cycle; return to IDLE.
- R_STATUS: addr 12'h300, wdata = mstatus_q with:
  - MIE <= MPIE
  - MPIE <= 1
  - MPP <= 2'b00
  - priv_we=1, priv_next = mstatus_q[12:11].
- R_REDIRECT: flush=1, redirect_valid=1, redirect_pc=mepc_q; go to IDLE.
- Latencies:
  - Trap: detect at cycle T; CSR writes at T+1..T+4; redirect/flush at T+5; IDLE at T+6.
  - mret: detect at T; status write at T+1; redirect at T+2.
- stall is high in every non-IDLE state.
- exc_code and mret_req are ignored while not IDLE. The pipeline is stalled, so a new cause must not be accepted mid-sequence.
- csr_we is high in exactly the W_* and R_STATUS states; it is never high in REDIRECT or R_REDIRECT.
- Only one of csr_we, redirect_valid is high in any cycle.
- All arithmetic is bit-selection only; there is no adder.

Decomposition:
- Shared package pfrv_trap_pkg holds:
  - CSR address constants (CSR_MSTATUS, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL).
  - mstatus bit-position constants (MIE, MPIE, MPP_LO/HI).
  - NO_EXC.
  - Privilege encodings.
  - The state enum.
- One natural sub-module: mstatus_update, a combinational pure function producing the trap-entry and mret mstatus values plus priv_next.

Test Plan:
- Load misalign: exc_code=4, exc_pc=0x8000_0010, tval=0x1003, cur_priv=0, mtvec=0x8000_0101, mstatus MIE=1.
  - Writes 0x341=0x80000010, 0x342=4, 0x343=0x1003 in consecutive cycles.
  - Then 0x300 with MIE=0, MPIE=1, MPP=0, priv_next=3.
  - Then redirect_pc=0x8000_0100 with flush; stall is high for exactly 5 cycles.
- U ecall: exc_code=8, tval=0xDEAD → mcause=8, mtval written 0.
- mret with mstatus MPP=0, MPIE=1, mepc=0x8000_0200:
  - Status write MIE=1, MPIE=1, MPP=0, priv_next=0.
  - Next cycle redirect_pc=0x8000_0200, flush=1.
- exc_code=2 and mret_req together → full trap sequence, no mret actions.
- exc_code=5 pulsed during W_CAUSE of a trap for code 2 → ignored; mcause=2; exactly 4 CSR writes.
- reset asserted in W_TVAL → next cycle all outputs 0, state IDLE, no redirect ever issued for that trap.
